// File: rtl/pixie_pkg.sv
// PIXIE shared definitions: CPU state codes, 1861 display geometry,
// sized compare constants and line-zone decode helpers.
package pixie_pkg;

    // CDP1802 state code as presented on SC1:SC0 at TPB.
    typedef enum logic [1:0] {
        SC_FETCH     = 2'b00,
        SC_EXECUTE   = 2'b01,
        SC_DMA       = 2'b10,
        SC_INTERRUPT = 2'b11
    } sc_t;

    // Display geometry (1861 timing).
    localparam int CYCLES_PER_LINE   = 14;
    localparam int LINES_PER_FRAME   = 262;
    localparam int FIRST_ACTIVE_LINE = 64;
    localparam int ACTIVE_LINES      = 128;
    localparam int BYTES_PER_LINE    = 8;
    localparam int DMA_START_CYCLE   = 2;
    localparam int INT_LEAD_LINES    = 2;
    localparam int EFX_LINES         = 4;

    // Counter and address widths.
    localparam int FB_ADDR_W  = 10;
    localparam int ROW_W      = 7;
    localparam int BYTE_IDX_W = 3;
    localparam int CYCLE_W    = 4;
    localparam int LINE_W     = 9;
    localparam int BYTE_W     = 4;

    // Sized constants so every compare is width-matched.
    localparam logic [CYCLE_W-1:0] LAST_CYCLE      = CYCLE_W'(CYCLES_PER_LINE - 1);
    localparam logic [CYCLE_W-1:0] DMA_FIRST_CYCLE = CYCLE_W'(DMA_START_CYCLE);
    localparam logic [LINE_W-1:0]  LAST_LINE       = LINE_W'(LINES_PER_FRAME - 1);
    localparam logic [LINE_W-1:0]  WINDOW_FIRST    = LINE_W'(FIRST_ACTIVE_LINE);
    localparam logic [LINE_W-1:0]  WINDOW_END      = LINE_W'(FIRST_ACTIVE_LINE + ACTIVE_LINES);
    localparam logic [LINE_W-1:0]  INT_FIRST       = LINE_W'(FIRST_ACTIVE_LINE - INT_LEAD_LINES);
    localparam logic [LINE_W-1:0]  EFX_LEAD_FIRST  = LINE_W'(FIRST_ACTIVE_LINE - EFX_LINES);
    localparam logic [LINE_W-1:0]  EFX_TAIL_FIRST  = LINE_W'(FIRST_ACTIVE_LINE + ACTIVE_LINES - EFX_LINES);
    localparam logic [BYTE_W-1:0]  BYTES_FULL      = BYTE_W'(BYTES_PER_LINE);

    // Line lies inside the display-fetch window.
    function automatic logic in_window(input logic [LINE_W-1:0] line);
        return (line >= WINDOW_FIRST) && (line < WINDOW_END);
    endfunction

    // Line lies in the two-line interrupt lead-in before the window.
    function automatic logic in_int_zone(input logic [LINE_W-1:0] line);
        return (line >= INT_FIRST) && (line < WINDOW_FIRST);
    endfunction

    // Line lies in the four lines before the window or the last four inside it.
    function automatic logic in_efx_zone(input logic [LINE_W-1:0] line);
        return ((line >= EFX_LEAD_FIRST) && (line < WINDOW_FIRST)) ||
               ((line >= EFX_TAIL_FIRST) && (line < WINDOW_END));
    endfunction

    // Frame-buffer address: {row, byte within row}.
    function automatic logic [FB_ADDR_W-1:0] fb_address(input logic [ROW_W-1:0]      row,
                                                        input logic [BYTE_IDX_W-1:0] byte_idx);
        return {row, byte_idx};
    endfunction

endpackage

// File: rtl/pixie_frame_timer.sv
// PIXIE frame timer: counts CPU machine cycles (TPB pulses) into a cycle
// within the scan line and a line within the frame, and decodes the
// display window and interrupt/EFx zones. Look-ahead (next-state) values
// are exported so the caller can register outputs that track the counters
// with no extra clock of lag.
module pixie_frame_timer
    import pixie_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tpb,
    output logic [LINE_W-1:0] line,
    output logic              window,
    output logic              line_wrap,
    output logic [CYCLE_W-1:0] cycle_next,
    output logic              window_next,
    output logic              int_zone_next,
    output logic              efx
);

    logic [CYCLE_W-1:0] cycle_q;
    logic [LINE_W-1:0]  line_q;
    logic [LINE_W-1:0]  line_next;

    // Next-state counter logic: advance only on tpb, line steps on cycle wrap.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can
        // leave it unassigned and infer a latch.
        cycle_next = cycle_q;
        line_next  = line_q;
        line_wrap  = tpb && (cycle_q == LAST_CYCLE);
        if (tpb) begin
            if (line_wrap) begin
                cycle_next = '0;
                line_next  = (line_q == LAST_LINE) ? '0 : line_q + 1'b1;
            end else begin
                cycle_next = cycle_q + 1'b1;
            end
        end
    end

    // Counter and EFx registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (!reset_n) begin
            cycle_q <= '0;
            line_q  <= '0;
            efx     <= 1'b0;
        end else begin
            cycle_q <= cycle_next;
            line_q  <= line_next;
            efx     <= in_efx_zone(line_next);
        end
    end

    assign line          = line_q;
    assign window        = in_window(line_q);
    assign window_next   = in_window(line_next);
    assign int_zone_next = in_int_zone(line_next);

endmodule

// File: rtl/pixie_dma_writer.sv
// PIXIE DMA writer: CPU-side front end of the PIXIE graphics core.
// Generates DMA-out, interrupt and EFx requests for the CDP1802 using the
// 1861 display protocol and writes every serviced DMA-out byte into the
// dual-port frame buffer at {row, byte}.
//
// Build option PIXIE_BLANK_ON_DISABLE_EN: when defined, a disabled display
// still walks the window and writes 8'h00 at each byte slot (no DMA request
// is raised), so the frame buffer reads blank. When undefined, a disabled
// display writes nothing and the frame buffer keeps its stale contents.
module pixie_dma_writer
    import pixie_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tpb,
    input  logic [1:0]           sc,
    input  logic [7:0]           data_in,
    input  logic                 disp_on,
    input  logic                 disp_off,
    output logic                 dma_out_req,
    output logic                 int_req,
    output logic                 efx,
    output logic                 fb_write_en,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [7:0]           fb_data
);

    logic [LINE_W-1:0]  line;
    logic               window;
    logic               line_wrap;
    logic [CYCLE_W-1:0] cycle_next;
    logic               window_next;
    logic               int_zone_next;

    logic               enable_req_q;
    logic               enable_q;
    logic [BYTE_W-1:0]  byte_count_q;

    logic               enable_req_next;
    logic               enable_next;
    logic [BYTE_W-1:0]  byte_next;
    logic               room;
    logic               dma_write;
    logic               blank_write;
    logic               do_write;
    logic [ROW_W-1:0]   row;
    logic               dma_req_next;
    logic               int_req_next;

    pixie_frame_timer u_timer (
        .clk           (clk),
        .reset_n       (reset_n),
        .tpb           (tpb),
        .line          (line),
        .window        (window),
        .line_wrap     (line_wrap),
        .cycle_next    (cycle_next),
        .window_next   (window_next),
        .int_zone_next (int_zone_next),
        .efx           (efx)
    );

    // Enable tracking, write qualification and look-ahead request decode.
    always_comb begin
        // A simultaneous on/off strobe leaves the display disabled.
        enable_req_next = enable_req_q;
        if (disp_off) begin
            enable_req_next = 1'b0;
        end else if (disp_on) begin
            enable_req_next = 1'b1;
        end

        // The effective enable only changes at a line boundary, so a line is
        // either fully fetched or not fetched at all.
        enable_next = line_wrap ? enable_req_q : enable_q;

        room      = byte_count_q < BYTES_FULL;
        dma_write = tpb && (sc_t'(sc) == SC_DMA) && enable_q && window && room;
`ifdef PIXIE_BLANK_ON_DISABLE_EN
        blank_write = tpb && !enable_q && window && room;
`else
        blank_write = 1'b0;
`endif
        do_write = dma_write || blank_write;
        row      = ROW_W'(line - WINDOW_FIRST);

        // Unserviced bytes are dropped at the line boundary, never carried.
        if (line_wrap) begin
            byte_next = '0;
        end else if (do_write) begin
            byte_next = byte_count_q + 1'b1;
        end else begin
            byte_next = byte_count_q;
        end

        dma_req_next = enable_next && window_next &&
                       (cycle_next >= DMA_FIRST_CYCLE) && (byte_next < BYTES_FULL);
        int_req_next = enable_next && int_zone_next;
    end

    // Control state, request outputs and frame-buffer write port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            enable_req_q <= 1'b0;
            enable_q     <= 1'b0;
            byte_count_q <= '0;
            dma_out_req  <= 1'b0;
            int_req      <= 1'b0;
            fb_write_en  <= 1'b0;
            fb_addr      <= '0;
            fb_data      <= '0;
        end else begin
            enable_req_q <= enable_req_next;
            enable_q     <= enable_next;
            byte_count_q <= byte_next;
            dma_out_req  <= dma_req_next;
            int_req      <= int_req_next;
            fb_write_en  <= do_write;
            if (do_write) begin
                fb_addr <= fb_address(row, byte_count_q[BYTE_IDX_W-1:0]);
                fb_data <= dma_write ? data_in : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_pixie_dma_writer.sv
// Self-checking bench for pixie_dma_writer: a frame-level behavioural model
// is stepped every clock and compared with the DUT, plus directed frames
// with hand-computed expectations for the display protocol corner cases.
module tb_pixie_dma_writer;

`ifdef PIXIE_BLANK_ON_DISABLE_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tpb = 1'b0;
    logic [1:0] sc = 2'b00;
    logic [7:0] data_in = 8'h00;
    logic       disp_on = 1'b0;
    logic       disp_off = 1'b0;
    logic       dma_out_req;
    logic       int_req;
    logic       efx;
    logic       fb_write_en;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;

    pixie_dma_writer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tpb         (tpb),
        .sc          (sc),
        .data_in     (data_in),
        .disp_on     (disp_on),
        .disp_off    (disp_off),
        .dma_out_req (dma_out_req),
        .int_req     (int_req),
        .efx         (efx),
        .fb_write_en (fb_write_en),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_armed = 1'b0;
    int m_cycle, m_line, m_bytes;
    bit m_en, m_en_req;
    bit e_dma, e_int, e_efx, e_we;
    int e_addr, e_data;

    // Advance the model by the inputs the DUT will sample at the next edge.
    task automatic model_step();
        bool_t_dummy();
        if (!reset_n) begin
            m_armed = 1'b1;
            m_cycle = 0; m_line = 0; m_bytes = 0;
            m_en = 0; m_en_req = 0;
            e_dma = 0; e_int = 0; e_efx = 0; e_we = 0; e_addr = 0; e_data = 0;
        end else begin
            e_we = 0;
            if (tpb) begin
                if (m_line >= 64 && m_line < 192 && m_bytes < 8) begin
                    if (m_en && sc == 2'b10) begin
                        e_we = 1; e_addr = (m_line - 64) * 8 + m_bytes; e_data = data_in; m_bytes++;
                    end else if (!m_en && BLANK) begin
                        e_we = 1; e_addr = (m_line - 64) * 8 + m_bytes; e_data = 0; m_bytes++;
                    end
                end
                m_cycle++;
                if (m_cycle == 14) begin
                    m_cycle = 0;
                    m_line  = (m_line + 1) % 262;
                    m_bytes = 0;
                    m_en    = m_en_req;
                end
            end
            if (disp_off) m_en_req = 0;
            else if (disp_on) m_en_req = 1;
            e_dma = m_en && m_line >= 64 && m_line < 192 && m_cycle >= 2 && m_bytes < 8;
            e_int = m_en && (m_line == 62 || m_line == 63);
            e_efx = (m_line >= 60 && m_line < 64) || (m_line >= 188 && m_line < 192);
        end
    endtask

    task automatic bool_t_dummy();
    endtask

    // ---------------- directed-test bookkeeping ----------------
    int         cur_line = 0;
    int         wr_cnt[262];
    int         first_addr[262];
    int         last_addr[262];
    logic [13:0] dma_mask[262];
    bit         int_seen[262];
    bit         efx_seen[262];
    logic [7:0] line64_data[8];
    int         total_writes, addr_seq_err, next_exp_addr, nonzero_writes;

    task automatic clear_stats();
        for (int i = 0; i < 262; i++) begin
            wr_cnt[i] = 0; first_addr[i] = -1; last_addr[i] = -1;
            dma_mask[i] = '0; int_seen[i] = 0; efx_seen[i] = 0;
        end
        for (int i = 0; i < 8; i++) line64_data[i] = 8'h00;
        total_writes = 0; addr_seq_err = 0; next_exp_addr = 0; nonzero_writes = 0;
    endtask

    // Compare against the model every cycle, log writes, then step the model.
    always @(negedge clk) begin
        if (m_armed) begin
            check("dma_out_req", dma_out_req, e_dma);
            check("int_req", int_req, e_int);
            check("efx", efx, e_efx);
            check("fb_write_en", fb_write_en, e_we);
            check("fb_addr", fb_addr, e_addr);
            check("fb_data", fb_data, e_data);
            if (fb_write_en === 1'b1) begin
                if (cur_line == 64 && wr_cnt[64] < 8) line64_data[wr_cnt[64]] = fb_data;
                wr_cnt[cur_line]++;
                if (wr_cnt[cur_line] == 1) first_addr[cur_line] = int'(fb_addr);
                last_addr[cur_line] = int'(fb_addr);
                total_writes++;
                if (int'(fb_addr) != next_exp_addr) addr_seq_err++;
                next_exp_addr = int'(fb_addr) + 1;
                if (fb_data != 8'h00) nonzero_writes++;
            end
        end
        model_step();
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0; tpb = 1'b1; sc = 2'b10; data_in = 8'hFF;
        @(posedge clk); #1;
        tpb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1; sc = 2'b00; data_in = 8'h00;
        cur_line = 0;
    endtask

    task automatic strobe(input bit on, input bit off);
        @(posedge clk); #1;
        disp_on = on; disp_off = off;
        @(posedge clk); #1;
        disp_on = 1'b0; disp_off = 1'b0;
    endtask

    // One scan line (or its first n_cycles machine cycles) of 4-clk machine cycles.
    task automatic run_line(input int max_serve, input bit force_dma, input int on_cycle, input int n_cycles);
        int served;
        served = 0;
        for (int c = 0; c < n_cycles; c++) begin
            bit serve;
            @(posedge clk); #1;
            if (dma_out_req === 1'b1) dma_mask[cur_line][c] = 1'b1;
            if (int_req === 1'b1) int_seen[cur_line] = 1'b1;
            if (efx === 1'b1) efx_seen[cur_line] = 1'b1;
            serve = (dma_out_req === 1'b1) && (served < max_serve);
            data_in = (cur_line == 64) ? 8'hA0 + 8'(served) : 8'(cur_line * 7 + served);
            sc = (serve || (force_dma && dma_out_req !== 1'b1 && c >= 2)) ? 2'b10 : 2'b00;
            tpb = 1'b1;
            disp_on = (c == on_cycle);
            if (serve) served++;
            @(posedge clk); #1;
            tpb = 1'b0; sc = 2'b00; disp_on = 1'b0;
            repeat (2) @(posedge clk);
        end
        if (n_cycles == 14) cur_line = (cur_line + 1) % 262;
    endtask

    task automatic run_frame(input int sp_line, input int sp_max, input bit force_dma,
                             input int on_line, input int on_cycle);
        for (int l = 0; l < 262; l++)
            run_line((l == sp_line) ? sp_max : 99, force_dma, (l == on_line) ? on_cycle : -1, 14);
    endtask

    function automatic int count_int_lines();
        int n = 0;
        for (int i = 0; i < 262; i++) if (int_seen[i]) n++;
        return n;
    endfunction

    function automatic int count_efx_lines();
        int n = 0;
        for (int i = 0; i < 262; i++) if (efx_seen[i]) n++;
        return n;
    endfunction

    function automatic int count_dma_lines();
        int n = 0;
        for (int i = 0; i < 262; i++) if (dma_mask[i] != '0) n++;
        return n;
    endfunction

    initial begin
        clear_stats();
        // Reset with tpb and a DMA state code asserted: must be ignored.
        do_reset();
        check("reset dma_out_req", dma_out_req, 0);
        check("reset int_req", int_req, 0);
        check("reset efx", efx, 0);
        check("reset fb_write_en", fb_write_en, 0);
        check("reset fb_addr", fb_addr, 0);
        check("reset fb_data", fb_data, 0);

        // Frame 1: display on, every request serviced.
        strobe(1'b1, 1'b0);
        clear_stats();
        run_frame(-1, 0, 1'b0, -1, -1);
        check("f1 total writes", total_writes, 1024);
        check("f1 address order errors", addr_seq_err, 0);
        check("f1 last address", last_addr[191], 1023);
        check("f1 int line count", count_int_lines(), 2);
        check("f1 int line 62", int_seen[62], 1);
        check("f1 int line 63", int_seen[63], 1);
        check("f1 efx line count", count_efx_lines(), 8);
        check("f1 line64 dma cycles", dma_mask[64], 14'h03FC);
        check("f1 line64 first addr", first_addr[64], 0);
        check("f1 line64 last addr", last_addr[64], 7);
        for (int i = 0; i < 8; i++) check("f1 line64 data", line64_data[i], 8'hA0 + 8'(i));

        // Frame 2: only 3 bytes serviced on line 70; stray DMA cycles elsewhere.
        clear_stats();
        run_frame(70, 3, 1'b1, -1, -1);
        check("f2 line70 writes", wr_cnt[70], 3);
        check("f2 line70 first addr", first_addr[70], 48);
        check("f2 line70 last addr", last_addr[70], 50);
        check("f2 line71 first addr", first_addr[71], 56);
        check("f2 total writes", total_writes, 1019);
        check("f2 line10 writes", wr_cnt[10], 0);

        // Frame 3: on and off in the same clock -> display disabled.
        strobe(1'b1, 1'b1);
        clear_stats();
        run_frame(-1, 0, 1'b1, -1, -1);
        check("f3 dma lines", count_dma_lines(), 0);
        check("f3 int lines", count_int_lines(), 0);
        check("f3 efx line count", count_efx_lines(), 8);
        check("f3 efx line 60", efx_seen[60], 1);
        check("f3 efx line 191", efx_seen[191], 1);
        check("f3 efx line 59", efx_seen[59], 0);
        check("f3 total writes", total_writes, BLANK ? 1024 : 0);
        check("f3 nonzero writes", nonzero_writes, 0);

        // Frame 4: disp_on at cycle 5 of line 64 takes effect on line 65.
        clear_stats();
        run_frame(-1, 0, 1'b0, 64, 5);
        check("f4 line64 dma cycles", dma_mask[64], 14'h0000);
        check("f4 int lines", count_int_lines(), 0);
        check("f4 line65 first addr", first_addr[65], 8);
        check("f4 line65 writes", wr_cnt[65], 8);
        check("f4 line65 dma cycles", dma_mask[65], 14'h03FC);
        check("f4 total writes", total_writes, BLANK ? 1024 : 1016);

        // Frame 5: reset in the middle of a serviced line.
        clear_stats();
        for (int l = 0; l < 100; l++) run_line(99, 1'b0, -1, 14);
        run_line(99, 1'b0, -1, 5);
        check("f5 line100 writes before reset", wr_cnt[100], 3);
        check("f5 line100 last addr", last_addr[100], 290);
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        check("f5 line100 writes after reset", wr_cnt[100], 3);
        check("f5 post-reset dma_out_req", dma_out_req, 0);
        check("f5 post-reset fb_write_en", fb_write_en, 0);
        check("f5 post-reset fb_addr", fb_addr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixie_dma_writer.md
# pixie_dma_writer

CPU-side front end of the PIXIE graphics core: tracks CDP1802 machine cycles, generates the interrupt, EFx and DMA-out requests of the 1861 display protocol, and writes each DMA-out byte into the dual-port frame buffer. It is the write end of the frame buffer drained by the PIXIE back end. Frame buffer address format is {row[6:0], byte[2:0]}, 64×128 pixels.

## Interface
- cycles_per_line, 14, machine cycles (TPB pulses) per scan line
- lines_per_frame, 262, scan lines per frame
- first_active_line, 64, first line that fetches display data
- active_lines, 128, number of display lines
- bytes_per_line, 8, DMA-out bytes per display line
- dma_start_cycle, 2, first machine cycle of a line that may request DMA
- clk  in  1  system clock
- reset_n  in  1  reset; one clock; reset is synchronous and active-low
- tpb  in  1  one-clk pulse marking the end of each CPU machine cycle
- sc  in  2  CPU state code, sampled at tpb; 2'b10 = DMA
- data_in  in  8  CPU data bus, sampled at tpb
- disp_on  in  1  one-clk strobe: enable display (decoded INP 1)
- disp_off  in  1  one-clk strobe: disable display (decoded OUT 1)
- dma_out_req  out  1  DMA-out request to CPU
- int_req  out  1  interrupt request to CPU
- efx  out  1  frame-timing flag to CPU EF input
- fb_write_en  out  1  frame buffer write strobe
- fb_addr  out  10  frame buffer write address
- fb_data  out  8  frame buffer write data

## Operation
- Counters advance only on tpb: cycle 0..cycles_per_line-1; on wrap, line 0..lines_per_frame-1, wrapping to 0.
- byte_count (0..bytes_per_line) clears at every line wrap; row = line - first_active_line.
- Display window: first_active_line ≤ line < first_active_line+active_lines.
- enable_req: set by disp_on, cleared by disp_off; both in same clk -> cleared. enable (effective) copies enable_req at each line wrap, so a line is never partially fetched.
- DMA write: tpb && sc==2'b10 && enable && window && byte_count<bytes_per_line -> write data_in at {row[6:0], byte_count[2:0]}, byte_count+1. DMA cycles outside these conditions are ignored.
- dma_out_req = enable && window && cycle ≥ dma_start_cycle && byte_count < bytes_per_line.
- Unserviced bytes at line end are skipped (not carried over); next line starts at byte 0.
- int_req = enable && line ∈ [first_active_line-2, first_active_line-1].
- efx = line ∈ [first_active_line-4, first_active_line-1] or the last 4 window lines; independent of enable.

## Timing
- Reset: all counters 0, enable/enable_req 0, every output 0.
- fb_write_en is a 1-clk pulse in the clk after the qualifying tpb; fb_addr/fb_data valid in that same clk and held until the next write.
- dma_out_req, int_req, efx registered; reflect new counter state 1 clk after the tpb that changed it; dma_out_req drops 1 clk after the tpb of the final byte.
- Reset mid-line: abandons line; no write pulse emitted from the reset clk onward.
- tpb during reset is ignored.

## Configuration
- PIXIE_BLANK_ON_DISABLE_EN defined: when enable=0, each tpb in the window with byte_count<bytes_per_line writes 8'h00 at the normal address (no DMA request raised), so a disabled display reads blank. Undefined: disabled display writes nothing; frame buffer keeps stale contents.

## Structure
- Package pixie_pkg: SC_DMA constant, default geometry constants, frame-buffer address width (10).
- Sub-module pixie_frame_timer: cycle/line counters, window, int and efx decode; top level keeps enable, byte_count and write path.

## Test plan
- Reset, disp_on, run one full frame of tpb with sc=DMA whenever dma_out_req -> exactly 1024 writes, addresses 0..1023 in order, int_req high lines 62–63 only.
- Line 64 with data_in 8'hA0..8'hA7 -> writes at fb_addr 0..7 with those bytes; dma_out_req low from cycle 10 of the line.
- Service only 3 DMA cycles on line 70 -> addrs 48..50 written, line 71 begins at addr 56.
- disp_on and disp_off in same clk -> no dma_out_req or int_req for whole frame; efx still high lines 60–63 and 188–191.
- disp_on at cycle 5 of line 64 -> no requests on line 64; first write at addr 8 on line 65.
- With PIXIE_BLANK_ON_DISABLE_EN, display disabled -> 1024 writes of 8'h00 per frame, dma_out_req never asserted.
